ddr_cmd_issuer: RTL and testbench
=================================

Name: ddr_cmd_issuer

Overview:
- Controller-side DDR4 command generator; drives the DIMM command/address bus that the DIMM model decodes.
- Accepts one read/write request at a time on a valid/ready handshake.
- Issues the sequence ACT -> RD/WR -> PRE (close-page), with tRCD, CAS/data, tWR and tRP spacing enforced by a down-counter.
- Also issues REF on request and holds the bus idle for tRFC.

Parameters:
- T_RCD, 4: cycles from ACT to RD/WR.
- T_CL, 6: read CAS latency.
- T_CWL, 5: write CAS latency.
- T_WR, 6: write recovery before PRE.
- T_RP, 4: cycles from PRE until the next command may be issued.
- T_RFC, 20: cycles from REF until the next command may be issued.
- BL, 8: burst length; legal values 8 or 4 (BC4).

Ports:
- CK_t  in  1  clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where valid && ready.
- req_rw  in  1  1 = write, 0 = read.
- req_bg  in  2  bank group.
- req_ba  in  2  bank.
- req_row  in  17  row address.
- req_col  in  10  column address.
- ref_req  in  1  refresh request (level).
- ref_ack  out  1  one-cycle pulse, coincident with REF on the bus.
- cmd_done  out  1  one-cycle pulse, coincident with PRE.
- busy  out  1  high whenever state != IDLE.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins.
- A13, A12_BC_n, A11, A10_AP  out  1 each  address pins.
- A9_A0  out  10  address pins.
- bg_addr  out  2  bank group pins.
- ba_addr  out  2  bank pins.

Behaviour:
- All bus outputs are registered and change only on the CK_t posedge, except req_ready.
- req_ready is combinational: (state==IDLE) && !ref_req && reset_n.
- Encoding of {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}:
  - DES = 1_1111.
  - ACT = 0_0 followed by row[16:14].
  - RD = 01101.
  - WR = 01100.
  - PRE = 01010.
  - REF = 01001.
- Reset (async assert): state IDLE, counter 0, bus = DES, all address pins/bg/ba = 0, ref_ack = cmd_done = busy = 0.
- Every cycle with no command in flight is DES; address pins hold their last values.
- Latched request registers: rw, bg, ba, row, col, captured at the accept edge.
- States:
  - IDLE:
    - If ref_req is high, go to REF; ref_req has priority over req_valid.
    - Otherwise, on valid && ready, latch the request and go to ACT.
  - ACT:
    - Bus carries ACT: bg/ba from latch; row[13:0] on A13..A9_A0.
    - ACT appears in the cycle immediately after the accept edge (call it cycle k).
    - Load counter with T_RCD-1; go to TRCD.
  - TRCD:
    - DES while counter != 0; decrement each cycle.
    - At 0, go to CAS; RD/WR appears at cycle k+T_RCD.
  - CAS:
    - Bus carries RD or WR; A9_A0 = col; A10_AP = 0.
    - A12_BC_n = 1 when BL==8, 0 when BL==4; A13 = A11 = 0.
    - Load counter with the data wait minus 1:
      - read: T_CL + BL/2;
      - write: T_CWL + BL/2 + T_WR.
    - Go to TDATA.
  - TDATA: count down with DES on the bus; at 0 go to PRE.
  - PRE:
    - Bus carries PRE with A10_AP = 0 and bg/ba from latch.
    - cmd_done = 1 for this cycle.
    - Load counter with T_RP-1; go to TRP.
  - TRP: DES; at 0 go to IDLE; req_ready may rise in the next cycle.
  - REF:
    - Bus carries REF; ref_ack = 1 for this cycle.
    - Load counter with T_RFC-1; go to TRFC.
  - TRFC: DES; at 0 go to IDLE.
- Counter is 8 bits; parameter combinations whose waits exceed 255 are illegal (checked by an elaboration-time assertion).
- Boundary conditions:
  - ref_req and req_valid both high in IDLE: REF is issued, the request is not accepted and must be held.
  - ref_req rising mid-sequence: ignored until IDLE; it is not aborted or lost while held high.
  - req_valid during a non-IDLE state: ignored; req_ready = 0.
  - Reset mid-sequence: bus returns to DES immediately. No PRE is issued; the in-flight request is discarded. Pulses clear.
  - Back-to-back requests: the minimum accept-to-accept spacing is the full sequence (no pipelining).

Test Plan:
- Reset: assert reset_n=0 mid-TDATA -> next sample shows cs_n=1, busy=0, cmd_done=0; after release with req_valid=1, req_ready=1.
- Read, defaults: accept {rw=0, bg=1, ba=2, row=0x1ABCD, col=0x155} -> ACT at k (bg=1, ba=2, row on pins), RD at k+4 with A9_A0=0x155 and A12_BC_n=1, PRE + cmd_done at k+14, req_ready high at k+18.
- Write, defaults: accept rw=1 -> WR at k+4, PRE at k+19, ready at k+23; with BL=4 -> A12_BC_n=0, PRE at k+17.
- Refresh priority: ref_req and req_valid both high in IDLE -> REF (01001) + ref_ack next cycle, req_ready=0, no ACT for 20 cycles, then request accepted.
- Refresh during read: raise ref_req at k+6 -> read completes unchanged; REF issued the cycle after TRP expires.
- Back-to-back: two queued reads -> second ACT exactly 19 cycles after first ACT; DES on every non-command cycle.

Source files
------------

// File: rtl/ddr_cmd_issuer.sv
// DDR4 close-page command issuer: ACT -> RD/WR -> PRE, plus REF.
// One request in flight; all spacing is driven by a single down-counter.
module ddr_cmd_issuer #(
  parameter int T_RCD = 4,
  parameter int T_CL  = 6,
  parameter int T_CWL = 5,
  parameter int T_WR  = 6,
  parameter int T_RP  = 4,
  parameter int T_RFC = 20,
  parameter int BL    = 8
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        cmd_done,
  output logic        busy,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr
);

  localparam int RD_WAIT = T_CL + BL / 2;
  localparam int WR_WAIT = T_CWL + BL / 2 + T_WR;

  localparam logic [4:0] CMD_DES = 5'b11111;
  localparam logic [4:0] CMD_RD  = 5'b01101;
  localparam logic [4:0] CMD_WR  = 5'b01100;
  localparam logic [4:0] CMD_PRE = 5'b01010;
  localparam logic [4:0] CMD_REF = 5'b01001;

  // The next command is launched on the same edge the counter runs out,
  // so every wait must span at least two cycles and fit the 8-bit counter.
  if (BL != 8 && BL != 4) begin : g_bad_bl
    $error("ddr_cmd_issuer: BL must be 8 or 4");
  end
  if (T_RCD < 2 || T_RP < 2 || T_RFC < 2 ||
      T_RCD > 256 || T_RP > 256 || T_RFC > 256 ||
      RD_WAIT > 256 || WR_WAIT > 256) begin : g_bad_timing
    $error("ddr_cmd_issuer: timing waits out of counter range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_CAS, S_TDATA,
    S_PRE, S_TRP, S_REF, S_TRFC
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  cmd;
  logic        lat_rw;
  logic [1:0]  lat_bg;
  logic [1:0]  lat_ba;
  logic [9:0]  lat_col;
  logic        last;

  assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd;
  assign req_ready = (state == S_IDLE) && !ref_req && reset_n;
  assign last = (cnt <= 8'd1);

  // Sequencer: state, counter and every registered bus/handshake output.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      cmd      <= CMD_DES;
      A13      <= 1'b0;
      A12_BC_n <= 1'b0;
      A11      <= 1'b0;
      A10_AP   <= 1'b0;
      A9_A0    <= 10'd0;
      bg_addr  <= 2'd0;
      ba_addr  <= 2'd0;
      ref_ack  <= 1'b0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      lat_rw   <= 1'b0;
      lat_bg   <= 2'd0;
      lat_ba   <= 2'd0;
      lat_col  <= 10'd0;
    end else begin
      cmd      <= CMD_DES;
      ref_ack  <= 1'b0;
      cmd_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ref_req) begin
            state   <= S_REF;
            cmd     <= CMD_REF;
            ref_ack <= 1'b1;
            busy    <= 1'b1;
          end else if (req_valid) begin
            lat_rw  <= req_rw;
            lat_bg  <= req_bg;
            lat_ba  <= req_ba;
            lat_col <= req_col;
            state   <= S_ACT;
            cmd     <= {2'b00, req_row[16:14]};
            {A13, A12_BC_n, A11, A10_AP} <= req_row[13:10];
            A9_A0   <= req_row[9:0];
            bg_addr <= req_bg;
            ba_addr <= req_ba;
            busy    <= 1'b1;
          end
        end
        S_ACT: begin
          cnt   <= 8'(T_RCD - 1);
          state <= S_TRCD;
        end
        S_TRCD: begin
          cnt <= cnt - 8'd1;
          if (last) begin
            state    <= S_CAS;
            cmd      <= lat_rw ? CMD_WR : CMD_RD;
            A9_A0    <= lat_col;
            A10_AP   <= 1'b0;
            A12_BC_n <= (BL == 8);
            A13      <= 1'b0;
            A11      <= 1'b0;
            bg_addr  <= lat_bg;
            ba_addr  <= lat_ba;
          end
        end
        S_CAS: begin
          cnt   <= lat_rw ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1);
          state <= S_TDATA;
        end
        S_TDATA: begin
          cnt <= cnt - 8'd1;
          if (last) begin
            state    <= S_PRE;
            cmd      <= CMD_PRE;
            A10_AP   <= 1'b0;
            bg_addr  <= lat_bg;
            ba_addr  <= lat_ba;
            cmd_done <= 1'b1;
          end
        end
        S_PRE: begin
          cnt   <= 8'(T_RP - 1);
          state <= S_TRP;
        end
        S_TRP: begin
          cnt <= cnt - 8'd1;
          if (last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_REF: begin
          cnt   <= 8'(T_RFC - 1);
          state <= S_TRFC;
        end
        S_TRFC: begin
          cnt <= cnt - 8'd1;
          if (last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer: read/write/refresh sequences,
// priority, reset mid-sequence, back-to-back spacing and BC4.
module tb_ddr_cmd_issuer;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RFC = 20;

  localparam logic [4:0] DES = 5'b11111;
  localparam logic [4:0] RD  = 5'b01101;
  localparam logic [4:0] WR  = 5'b01100;
  localparam logic [4:0] PRE = 5'b01010;
  localparam logic [4:0] REF = 5'b01001;

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_bg = 2'd0;
  logic [1:0]  req_ba = 2'd0;
  logic [16:0] req_row = 17'd0;
  logic [9:0]  req_col = 10'd0;
  logic        ref_req = 1'b0;

  logic       rdy  [2];
  logic       ack  [2];
  logic       done [2];
  logic       bsy  [2];
  logic       cs   [2];
  logic       actn [2];
  logic       ras  [2];
  logic       cas  [2];
  logic       we   [2];
  logic       a13  [2];
  logic       a12  [2];
  logic       a11  [2];
  logic       a10  [2];
  logic [9:0] a90  [2];
  logic [1:0] bgo  [2];
  logic [1:0] bao  [2];

  int sel = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int t0, t1;

  ddr_cmd_issuer u_bl8 (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy[0]),
    .req_rw(req_rw), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ack[0]),
    .cmd_done(done[0]), .busy(bsy[0]),
    .cs_n(cs[0]), .act_n(actn[0]), .RAS_n_A16(ras[0]),
    .CAS_n_A15(cas[0]), .WE_n_A14(we[0]),
    .A13(a13[0]), .A12_BC_n(a12[0]), .A11(a11[0]),
    .A10_AP(a10[0]), .A9_A0(a90[0]),
    .bg_addr(bgo[0]), .ba_addr(bao[0])
  );

  ddr_cmd_issuer #(.BL(4)) u_bc4 (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy[1]),
    .req_rw(req_rw), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ack[1]),
    .cmd_done(done[1]), .busy(bsy[1]),
    .cs_n(cs[1]), .act_n(actn[1]), .RAS_n_A16(ras[1]),
    .CAS_n_A15(cas[1]), .WE_n_A14(we[1]),
    .A13(a13[1]), .A12_BC_n(a12[1]), .A11(a11[1]),
    .A10_AP(a10[1]), .A9_A0(a90[1]),
    .bg_addr(bgo[1]), .ba_addr(bao[1])
  );

  always #5 CK_t = ~CK_t;

  always @(posedge CK_t) cyc <= cyc + 1;

  function automatic logic [4:0] cmd_now();
    return {cs[sel], actn[sel], ras[sel], cas[sel], we[sel]};
  endfunction

  function automatic logic [13:0] row_now();
    return {a13[sel], a12[sel], a11[sel], a10[sel], a90[sel]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one request from IDLE (at a negedge) and check every cycle
  // through to the IDLE cycle after TRP.
  task automatic run_req(input logic rw, input logic [1:0] bg,
                         input logic [1:0] ba, input logic [16:0] row,
                         input logic [9:0] col, input int dlen,
                         input logic bc, input int ref_at,
                         output int act_t);
    int pre_t;
    pre_t = T_RCD + dlen;
    req_valid = 1'b1;
    req_rw    = rw;
    req_bg    = bg;
    req_ba    = ba;
    req_row   = row;
    req_col   = col;
    chk("accept_ready", rdy[sel], 1);
    @(negedge CK_t);
    req_valid = 1'b0;
    act_t = cyc;
    chk("act_cmd", cmd_now(), {2'b00, row[16:14]});
    chk("act_row", row_now(), row[13:0]);
    chk("act_bgba", {bgo[sel], bao[sel]}, {bg, ba});
    chk("act_busy", bsy[sel], 1);
    for (int i = 1; i < pre_t + T_RP; i++) begin
      @(negedge CK_t);
      if (i == ref_at) ref_req = 1'b1;
      if (i == T_RCD) begin
        chk("cas_cmd", cmd_now(), rw ? WR : RD);
        chk("cas_col", a90[sel], col);
        chk("cas_a10", a10[sel], 0);
        chk("cas_bc", a12[sel], bc);
        chk("cas_a13_a11", {a13[sel], a11[sel]}, 0);
        chk("cas_bgba", {bgo[sel], bao[sel]}, {bg, ba});
      end else if (i == pre_t) begin
        chk("pre_cmd", cmd_now(), PRE);
        chk("pre_done", done[sel], 1);
        chk("pre_a10", a10[sel], 0);
        chk("pre_bgba", {bgo[sel], bao[sel]}, {bg, ba});
      end else begin
        chk("des_cmd", cmd_now(), DES);
        chk("des_done", done[sel], 0);
      end
      chk("seq_ready", rdy[sel], 0);
      chk("seq_busy", bsy[sel], 1);
    end
    @(negedge CK_t);
    chk("idle_busy", bsy[sel], 0);
    chk("idle_ready", rdy[sel], (ref_at < 0) ? 1 : 0);
  endtask

  // REF cycle (at current negedge) followed by the TRFC quiet window.
  task automatic check_ref();
    chk("ref_cmd", cmd_now(), REF);
    chk("ref_ack", ack[sel], 1);
    chk("ref_busy", bsy[sel], 1);
    ref_req = 1'b0;
    for (int i = 1; i < T_RFC; i++) begin
      @(negedge CK_t);
      chk("trfc_cmd", cmd_now(), DES);
      chk("trfc_ack", ack[sel], 0);
      chk("trfc_ready", rdy[sel], 0);
    end
    @(negedge CK_t);
    chk("trfc_end_busy", bsy[sel], 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    @(negedge CK_t);
    chk("rst_cmd", cmd_now(), DES);
    chk("rst_addr", {row_now(), bgo[sel], bao[sel]}, 0);
    chk("rst_flags", {bsy[sel], done[sel], ack[sel]}, 0);
    chk("rst_ready", rdy[sel], 0);
    reset_n = 1'b1;
    #1 chk("rel_ready", rdy[sel], 1);
    @(negedge CK_t);

    run_req(1'b0, 2'd1, 2'd2, 17'h1ABCD, 10'h155, 10, 1'b1, -1, t0);
    run_req(1'b1, 2'd3, 2'd1, 17'h0F0F0, 10'h2AA, 15, 1'b1, -1, t0);

    ref_req   = 1'b1;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_bg    = 2'd2;
    req_ba    = 2'd3;
    req_row   = 17'h00123;
    req_col   = 10'h011;
    #1 chk("prio_ready", rdy[sel], 0);
    @(negedge CK_t);
    check_ref();
    chk("prio_held_ready", rdy[sel], 1);
    run_req(1'b0, 2'd2, 2'd3, 17'h00123, 10'h011, 10, 1'b1, -1, t0);

    run_req(1'b0, 2'd0, 2'd1, 17'h10001, 10'h3FF, 10, 1'b1, 6, t0);
    @(negedge CK_t);
    check_ref();

    run_req(1'b0, 2'd1, 2'd1, 17'h05555, 10'h001, 10, 1'b1, -1, t0);
    run_req(1'b0, 2'd2, 2'd0, 17'h0AAAA, 10'h200, 10, 1'b1, -1, t1);
    chk("b2b_gap", t1 - t0, 19);

    req_valid = 1'b1;
    req_row   = 17'h1FFFF;
    @(negedge CK_t);
    req_valid = 1'b0;
    repeat (8) @(negedge CK_t);
    chk("mid_busy", bsy[sel], 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_cs", cs[sel], 1);
    chk("mrst_cmd", cmd_now(), DES);
    chk("mrst_busy", bsy[sel], 0);
    chk("mrst_done", done[sel], 0);
    @(negedge CK_t);
    reset_n   = 1'b1;
    req_valid = 1'b1;
    #1 chk("mrst_ready", rdy[sel], 1);
    req_valid = 1'b0;
    @(negedge CK_t);
    chk("mrst_idle_cmd", cmd_now(), DES);

    sel = 1;
    run_req(1'b1, 2'd1, 2'd0, 17'h0C3C3, 10'h0F0, 13, 1'b0, -1, t0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
